// File: rtl/rvsteel_gpio_irq_pkg.sv
// Shared register map constants and helpers for the GPIO block with edge interrupts.
package rvsteel_gpio_irq_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned BUS_W     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_IN      = 4'd0;
    localparam reg_idx_t REG_OE      = 4'd1;
    localparam reg_idx_t REG_OUT     = 4'd2;
    localparam reg_idx_t REG_CLR     = 4'd3;
    localparam reg_idx_t REG_SET     = 4'd4;
    localparam reg_idx_t REG_TOG     = 4'd5;
    localparam reg_idx_t REG_RISE_EN = 4'd6;
    localparam reg_idx_t REG_FALL_EN = 4'd7;
    localparam reg_idx_t REG_PEND    = 4'd8;

    // Writes land only for full-word, word-aligned accesses.
    function automatic logic write_accepted(input logic       request,
                                            input logic [1:0] address_lo,
                                            input logic [3:0] strobe);
        return request && (address_lo == 2'b00) && (strobe == 4'b1111);
    endfunction

endpackage

// File: rtl/rvsteel_gpio_edge_detect.sv
// Input synchroniser, one-cycle history and per-pin rise/fall event detection.
// RVSTEEL_GPIO_SYNC_EN selects a two-flop synchroniser instead of a single input register.
module rvsteel_gpio_edge_detect
    import rvsteel_gpio_irq_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GPIO_WIDTH-1:0] gpio_input,
    input  logic [GPIO_WIDTH-1:0] rise_en,
    input  logic [GPIO_WIDTH-1:0] fall_en,
    output logic [GPIO_WIDTH-1:0] sync_value,
    output logic [GPIO_WIDTH-1:0] pin_event_c
);

    logic [GPIO_WIDTH-1:0] prev;

`ifdef RVSTEEL_GPIO_SYNC_EN
    logic [GPIO_WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta       <= '0;
            sync_value <= '0;
        end else begin
            meta       <= gpio_input;
            sync_value <= meta;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_value <= '0;
        end else begin
            sync_value <= gpio_input;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= sync_value;
        end
    end

    assign pin_event_c = (sync_value & ~prev & rise_en) | (~sync_value & prev & fall_en);

endmodule

// File: rtl/rvsteel_gpio_irq.sv
// Memory-mapped GPIO with output set/clear/toggle and edge-triggered level interrupt.
// Input path latency is set by RVSTEEL_GPIO_SYNC_EN (see rvsteel_gpio_edge_detect).
module rvsteel_gpio_irq
    import rvsteel_gpio_irq_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            rw_address,
    output logic [31:0]           read_data,
    input  logic                  read_request,
    output logic                  read_response,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    input  logic                  write_request,
    output logic                  write_response,
    input  logic [GPIO_WIDTH-1:0] gpio_input,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic [GPIO_WIDTH-1:0] gpio_output,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] oe_q, out_q, rise_en_q, fall_en_q, pend_q;
    logic [GPIO_WIDTH-1:0] oe_d, out_d, rise_en_d, fall_en_d, pend_d, pend_clr;
    logic [GPIO_WIDTH-1:0] sync_value, pin_event_c;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [BUS_W-1:0]      rd_value;
    reg_idx_t              index;
    logic                  aligned;
    logic                  wr_en;
    logic                  unused_write_bits;

    assign index             = rw_address[5:2];
    assign aligned           = (rw_address[1:0] == 2'b00);
    assign wr_en             = write_accepted(write_request, rw_address[1:0], write_strobe);
    assign wdata             = write_data[GPIO_WIDTH-1:0];
    assign unused_write_bits = ^write_data;

    rvsteel_gpio_edge_detect #(
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_edge_detect (
        .clock       (clock),
        .reset       (reset),
        .gpio_input  (gpio_input),
        .rise_en     (rise_en_q),
        .fall_en     (fall_en_q),
        .sync_value  (sync_value),
        .pin_event_c (pin_event_c)
    );

    // Register write decode; a new event overrides a same-cycle PEND clear.
    always_comb begin
        oe_d      = oe_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        if (wr_en) begin
            case (index)
                REG_OE:      oe_d      = wdata;
                REG_OUT:     out_d     = wdata;
                REG_CLR:     out_d     = out_q & ~wdata;
                REG_SET:     out_d     = out_q | wdata;
                REG_TOG:     out_d     = out_q ^ wdata;
                REG_RISE_EN: rise_en_d = wdata;
                REG_FALL_EN: fall_en_d = wdata;
                REG_PEND:    pend_clr  = wdata;
                default:     ;
            endcase
        end
        pend_d = (pend_q & ~pend_clr) | pin_event_c;
    end

    always_comb begin
        rd_value = '0;
        case (index)
            REG_IN:      rd_value = BUS_W'(sync_value);
            REG_OE:      rd_value = BUS_W'(oe_q);
            REG_OUT:     rd_value = BUS_W'(out_q);
            REG_RISE_EN: rd_value = BUS_W'(rise_en_q);
            REG_FALL_EN: rd_value = BUS_W'(fall_en_q);
            REG_PEND:    rd_value = BUS_W'(pend_q);
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oe_q           <= '0;
            out_q          <= '0;
            rise_en_q      <= '0;
            fall_en_q      <= '0;
            pend_q         <= '0;
            read_data      <= '0;
            read_response  <= 1'b0;
            write_response <= 1'b0;
        end else begin
            oe_q           <= oe_d;
            out_q          <= out_d;
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            pend_q         <= pend_d;
            read_response  <= read_request;
            write_response <= write_request;
            if (read_request && aligned) begin
                read_data <= rd_value;
            end
        end
    end

    assign gpio_oe     = oe_q;
    assign gpio_output = out_q;
    assign irq         = |pend_q;

endmodule

// File: tb/tb_rvsteel_gpio_irq.sv
// Directed self-checking bench for rvsteel_gpio_irq (latency follows RVSTEEL_GPIO_SYNC_EN).
module tb_rvsteel_gpio_irq;

`ifdef RVSTEEL_GPIO_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    logic [7:0]  gpio_input;
    logic [7:0]  gpio_oe;
    logic [7:0]  gpio_output;
    logic        irq;

    int pass_count = 0;
    int total_count = 0;
    logic [31:0] rd;

    rvsteel_gpio_irq #(.GPIO_WIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .gpio_input     (gpio_input),
        .gpio_oe        (gpio_oe),
        .gpio_output    (gpio_output),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clock);
        rw_address    = addr;
        write_data    = data;
        write_strobe  = strb;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        check("write_response", 32'(write_response), 32'd1);
    endtask

    task automatic do_read(input logic [5:0] addr, output logic [31:0] data);
        @(negedge clock);
        rw_address   = addr;
        read_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
        check("read_response", 32'(read_response), 32'd1);
        data = read_data;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        rw_address = '0; write_data = '0; write_strobe = '0;
        write_request = 1'b0; read_request = 1'b0; gpio_input = '0;
        wait_cycles(2);
        check("reset_oe", 32'(gpio_oe), 32'h0);
        check("reset_out", 32'(gpio_output), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdata", read_data, 32'h0);
        check("reset_rresp", 32'(read_response), 32'h0);
        check("reset_wresp", 32'(write_response), 32'h0);
        reset = 1'b0;

        // Output enables and values
        do_write(6'h04, 32'h0000_00FF, 4'hF);
        check("oe_ff", 32'(gpio_oe), 32'hFF);
        do_write(6'h08, 32'h0000_00A5, 4'hF);
        check("out_a5", 32'(gpio_output), 32'hA5);
        do_write(6'h10, 32'h0000_000A, 4'hF);
        check("set_0a", 32'(gpio_output), 32'hAF);
        do_write(6'h0C, 32'h0000_0003, 4'hF);
        check("clr_03", 32'(gpio_output), 32'hAC);
        do_write(6'h14, 32'h0000_00FF, 4'hF);
        check("tog_ff", 32'(gpio_output), 32'h53);

        // Reads, write-only registers and unmapped indices
        do_read(6'h04, rd);
        check("rd_oe", rd, 32'hFF);
        do_read(6'h0C, rd);
        check("rd_clr_zero", rd, 32'h0);
        do_read(6'h08, rd);
        check("rd_out", rd, 32'h53);
        do_read(6'h05, rd);
        check("rd_misaligned_holds", rd, 32'h53);
        do_read(6'h30, rd);
        check("rd_idx12", rd, 32'h0);

        // Ignored writes are still acknowledged
        do_write(6'h08, 32'h0000_0000, 4'b0011);
        check("partial_strobe_ignored", 32'(gpio_output), 32'h53);
        do_write(6'h09, 32'h0000_0000, 4'hF);
        check("misaligned_ignored", 32'(gpio_output), 32'h53);

        // Rising edge on pin 0
        do_write(6'h18, 32'h0000_0001, 4'hF);
        gpio_input = 8'h01;
        wait_cycles(LAT - 1);
        check("rise_irq_early", 32'(irq), 32'h0);
        wait_cycles(1);
        check("rise_irq_on_time", 32'(irq), 32'h1);
        do_read(6'h20, rd);
        check("rise_pend", rd, 32'h01);
        do_read(6'h00, rd);
        check("in_value", rd, 32'h01);
        do_write(6'h20, 32'h0000_0001, 4'hF);
        check("pend_w1c_irq", 32'(irq), 32'h0);

        // Disabling an enable keeps the pending bit
        do_write(6'h18, 32'h0000_0002, 4'hF);
        gpio_input = 8'h03;
        wait_cycles(LAT);
        check("rise1_irq", 32'(irq), 32'h1);
        do_write(6'h18, 32'h0000_0000, 4'hF);
        check("en_clear_keeps_irq", 32'(irq), 32'h1);
        do_read(6'h20, rd);
        check("en_clear_keeps_pend", rd, 32'h02);
        do_write(6'h20, 32'h0000_0002, 4'hF);
        check("pend1_cleared", 32'(irq), 32'h0);

        // Falling edge on pin 7, then a W1C colliding with a new falling edge
        do_write(6'h1C, 32'h0000_0080, 4'hF);
        gpio_input = 8'h83;
        wait_cycles(LAT + 1);
        check("rise7_no_pend", 32'(irq), 32'h0);
        gpio_input = 8'h03;
        wait_cycles(LAT);
        check("fall7_irq", 32'(irq), 32'h1);
        gpio_input = 8'h83;
        wait_cycles(LAT + 1);
        gpio_input = 8'h03;
        wait_cycles(LAT - 1);
        rw_address    = 6'h20;
        write_data    = 32'h0000_0080;
        write_strobe  = 4'hF;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        check("collision_wresp", 32'(write_response), 32'h1);
        check("collision_irq", 32'(irq), 32'h1);
        wait_cycles(1);
        check("collision_irq_held", 32'(irq), 32'h1);
        do_read(6'h20, rd);
        check("collision_pend", rd, 32'h80);
        do_write(6'h20, 32'h0000_0080, 4'hF);
        check("pend7_cleared", 32'(irq), 32'h0);

        // Reset during an outstanding read
        gpio_input = 8'h83;
        wait_cycles(LAT + 1);
        gpio_input = 8'h03;
        wait_cycles(LAT + 1);
        check("pre_reset_irq", 32'(irq), 32'h1);
        @(negedge clock);
        rw_address   = 6'h04;
        read_request = 1'b1;
        @(posedge clock);
        #1;
        check("pre_reset_rresp", 32'(read_response), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_rresp", 32'(read_response), 32'h0);
        check("rst_rdata", read_data, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_out", 32'(gpio_output), 32'h0);
        read_request = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_read(6'h1C, rd);
        check("rst_fall_en", rd, 32'h0);
        do_read(6'h20, rd);
        check("rst_pend", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
